// File: rtl/seg_seq_ctrl_if.sv
// seg_seq_ctrl_if: control/display bundle of the one-hot sequencer.
// Master drives the requests; slave returns value, SEG and LED.
interface seg_seq_ctrl_if;
  logic       run;
  logic       step;
  logic       clr;
  logic       dir;
  logic [3:0] value;
  logic [7:0] SEG;
  logic [7:0] LED;

  modport master (
    output run, step, clr, dir,
    input  value, SEG, LED
  );

  modport slave (
    input  run, step, clr, dir,
    output value, SEG, LED
  );
endinterface

// File: rtl/seg_seq_ctrl.sv
// seg_seq_ctrl: one-hot 1/2/4/8 sequencer, prescaled auto-run or single step.
// Define SEG_SEQ_BOUNCE_EN for ping-pong order (dir is then ignored).
module seg_seq_ctrl #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic          clk_2,
  input  logic          reset,
  seg_seq_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  localparam logic [15:0] TERM = 16'(TICK_DIV - 1);

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] presc_q, presc_d;
  logic        step_q;
  logic        step_edge;
  logic        adv;
  logic [1:0]  idx_adv;
  logic        flag_led;

  logic [3:0]  value_o;
  logic [7:0]  seg_o;
  logic [7:0]  led_o;

  assign step_edge = bus.step & ~step_q;

`ifdef SEG_SEQ_BOUNCE_EN
  logic flag_q, flag_d, flag_adv;

  // Turn around at either end; the flag marks the descending leg.
  always_comb begin
    idx_adv  = idx_q + 2'd1;
    flag_adv = flag_q;
    if (!flag_q && idx_q == 2'd3) begin
      flag_adv = 1'b1;
      idx_adv  = 2'd2;
    end else if (flag_q && idx_q == 2'd0) begin
      flag_adv = 1'b0;
      idx_adv  = 2'd1;
    end else if (flag_q) begin
      idx_adv  = idx_q - 2'd1;
    end
  end

  always_comb begin
    flag_d = adv ? flag_adv : flag_q;
    if (bus.clr) flag_d = 1'b0;
  end

  always_ff @(posedge clk_2) begin
    if (reset) flag_q <= 1'b0;
    else       flag_q <= flag_d;
  end

  assign flag_led = flag_q;
`else
  assign idx_adv  = bus.dir ? idx_q - 2'd1 : idx_q + 2'd1;
  assign flag_led = 1'b0;
`endif

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      presc_q <= '0;
      step_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      presc_q <= presc_d;
      step_q  <= bus.step;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    presc_d = presc_q;
    adv     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.run) begin
          state_d = RUN;
          presc_d = '0;
        end else begin
          adv = step_edge;
        end
      end
      RUN: begin
        if (!bus.run) begin
          state_d = PAUSE;
        end else if (presc_q == TERM) begin
          presc_d = '0;
          adv     = 1'b1;
        end else begin
          presc_d = presc_q + 16'd1;
        end
      end
      PAUSE: begin
        adv = step_edge;
        if (bus.run) begin
          state_d = RUN;
          presc_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        presc_d = '0;
      end
    endcase
    if (adv) idx_d = idx_adv;
    // clr overrides everything, including a coincident step edge.
    if (bus.clr) begin
      state_d = IDLE;
      idx_d   = '0;
      presc_d = '0;
    end
  end

  always_comb begin
    value_o = 4'b0001 << idx_q;
    unique case (idx_q)
      2'd0:    seg_o = 8'h06;
      2'd1:    seg_o = 8'h5b;
      2'd2:    seg_o = 8'h66;
      default: seg_o = 8'h7f;
    endcase
    led_o = {flag_led, 1'b0, state_q, value_o};
  end

  assign bus.value = value_o;
  assign bus.SEG   = seg_o;
  assign bus.LED   = led_o;
endmodule

// File: tb/tb_seg_seq_ctrl.sv
// tb_seg_seq_ctrl: directed scenarios plus random traffic against a
// value-level reference model of the sequencer.
module tb_seg_seq_ctrl;
`ifdef SEG_SEQ_BOUNCE_EN
  localparam int TD = 1;
`else
  localparam int TD = 4;
`endif
  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;

  logic clk_2 = 1'b0;
  logic reset;
  seg_seq_ctrl_if bus ();

  seg_seq_ctrl #(.TICK_DIV(TD)) dut (
    .clk_2 (clk_2),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk_2 = ~clk_2;

  int n_cmp = 0;
  int n_err = 0;

  int m_val;
  int m_st;
  int m_cnt;
  bit m_stepq;
  bit m_flag;

  function automatic logic [7:0] seg_of(int v);
    case (v)
      1:       return 8'h06;
      2:       return 8'h5b;
      4:       return 8'h66;
      default: return 8'h7f;
    endcase
  endfunction

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_adv();
`ifdef SEG_SEQ_BOUNCE_EN
    if (!m_flag) begin
      if (m_val == 8) begin m_flag = 1; m_val = 4; end
      else m_val = m_val * 2;
    end else begin
      if (m_val == 1) begin m_flag = 0; m_val = 2; end
      else m_val = m_val / 2;
    end
`else
    if (bus.dir) m_val = (m_val == 1) ? 8 : m_val / 2;
    else         m_val = (m_val == 8) ? 1 : m_val * 2;
`endif
  endtask

  task automatic model_edge();
    bit se;
    se = bus.step && !m_stepq;
    if (reset) begin
      m_val = 1; m_st = S_IDLE; m_cnt = 0; m_stepq = 1; m_flag = 0;
      return;
    end
    m_stepq = bus.step;
    if (bus.clr) begin
      m_val = 1; m_st = S_IDLE; m_cnt = 0; m_flag = 0;
      return;
    end
    case (m_st)
      S_IDLE: begin
        if (bus.run) begin m_st = S_RUN; m_cnt = 0; end
        else if (se) model_adv();
      end
      S_RUN: begin
        if (!bus.run) m_st = S_PAUSE;
        else begin
          m_cnt++;
          if (m_cnt == TD) begin m_cnt = 0; model_adv(); end
        end
      end
      default: begin
        if (se) model_adv();
        if (bus.run) begin m_st = S_RUN; m_cnt = 0; end
      end
    endcase
  endtask

  task automatic tick();
    logic [7:0] e_led;
    @(posedge clk_2);
    model_edge();
    #1;
    e_led = {m_flag, 1'b0, 2'(m_st), 4'(m_val)};
    chk("value", {4'h0, bus.value}, 8'(m_val));
    chk("seg", bus.SEG, seg_of(m_val));
    chk("led", bus.LED, e_led);
  endtask

  initial begin
    logic [3:0] up_seq [4];
    logic [3:0] bn_val [7];
    logic       bn_flg [7];
    up_seq = '{4'd2, 4'd4, 4'd8, 4'd1};
    bn_val = '{4'd2, 4'd4, 4'd8, 4'd4, 4'd2, 4'd1, 4'd2};
    bn_flg = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    reset = 1'b1;
    bus.run = 1'b0; bus.step = 1'b1; bus.clr = 1'b0; bus.dir = 1'b0;
    m_val = 1; m_st = S_IDLE; m_cnt = 0; m_stepq = 1; m_flag = 0;

    // reset release with step held high
    tick(); tick();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("rel_value", {4'h0, bus.value}, 8'h01);
    end
    chk("rel_seg", bus.SEG, 8'h06);
    chk("rel_led", bus.LED, 8'h01);
    bus.step = 1'b0;
    tick();

    // auto advance
    bus.run = 1'b1;
    tick();
    chk("run_state", {6'h0, bus.LED[5:4]}, 8'd1);
`ifndef SEG_SEQ_BOUNCE_EN
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k % 4 == 0)
        chk("auto_value", {4'h0, bus.value}, {4'h0, up_seq[k/4-1]});
    end
    for (int k = 0; k < 8; k++) tick();
    chk("pre_pause_value", {4'h0, bus.value}, 8'h04);

    // pause, then three steps downward
    bus.run = 1'b0;
    tick();
    chk("pause_state", {6'h0, bus.LED[5:4]}, 8'd2);
    bus.dir = 1'b1;
    bus.step = 1'b1; tick(); chk("step1", {4'h0, bus.value}, 8'h02);
    bus.step = 1'b0; tick();
    bus.step = 1'b1; tick(); chk("step2", {4'h0, bus.value}, 8'h01);
    bus.step = 1'b0; tick();
    bus.step = 1'b1; tick(); chk("step3", {4'h0, bus.value}, 8'h08);
    chk("step3_seg", bus.SEG, 8'h7f);
    bus.step = 1'b0; tick();

    // run falls on the terminal prescaler edge
    bus.run = 1'b1;
    tick();
    for (int k = 0; k < TD - 1; k++) tick();
    bus.run = 1'b0;
    tick();
    chk("term_fall_value", {4'h0, bus.value}, 8'h08);
    chk("term_fall_state", {6'h0, bus.LED[5:4]}, 8'd2);
`endif

    // clr with a step edge in the same cycle
    bus.run = 1'b0; bus.step = 1'b0; bus.dir = 1'b0;
    tick();
    bus.clr = 1'b1; bus.step = 1'b1;
    tick();
    chk("clr_value", {4'h0, bus.value}, 8'h01);
    chk("clr_state", {6'h0, bus.LED[5:4]}, 8'd0);
    bus.clr = 1'b0; bus.step = 1'b0;
    tick();

    // reset in RUN with prescaler at its terminal count
    bus.run = 1'b1;
    tick();
    for (int k = 0; k < TD - 1; k++) tick();
    reset = 1'b1;
    tick();
    chk("rst_mid_value", {4'h0, bus.value}, 8'h01);
    chk("rst_mid_state", {6'h0, bus.LED[5:4]}, 8'd0);
    reset = 1'b0;
    tick();
    for (int k = 0; k < TD - 1; k++) tick();
    chk("rst_mid_noadv", {4'h0, bus.value}, 8'h01);
    tick();
    chk("rst_mid_adv", {4'h0, bus.value}, 8'h02);

`ifdef SEG_SEQ_BOUNCE_EN
    // ping-pong sequence on consecutive edges
    bus.run = 1'b0; bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0; bus.run = 1'b1;
    tick();
    chk("bn_entry", {4'h0, bus.value}, 8'h01);
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("bn_value", {4'h0, bus.value}, {4'h0, bn_val[k]});
      chk("bn_flag", {7'h0, bus.LED[7]}, {7'h0, bn_flg[k]});
    end
`endif

    // random traffic against the model
    for (int k = 0; k < 600; k++) begin
      bus.run  = ($urandom_range(0, 9) < 7);
      bus.step = 1'($urandom_range(0, 1));
      bus.clr  = ($urandom_range(0, 39) == 0);
      bus.dir  = 1'($urandom_range(0, 1));
      reset    = ($urandom_range(0, 79) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/seg_seq_ctrl.md
SEG_SEQ_CTRL -- requirements
Module: seg_seq_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 4, meaning clk_2 cycles per automatic advance; legal range is 1..2^16, with a 16-bit prescaler.
REQ-002 The block SHALL have port clk_2, input, width 1: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, width 1: synchronous, active-high reset.
REQ-004 The block SHALL have port run, input, width 1: level request for automatic sequencing.
REQ-005 The block SHALL have port step, input, width 1: single-advance request, rising-edge detected internally.
REQ-006 The block SHALL have port clr, input, width 1: synchronous return to the initial value and IDLE.
REQ-007 The block SHALL have port dir, input, width 1: 0 = up (1,2,4,8), 1 = down (8,4,2,1).
REQ-008 The block SHALL have port value, output, width 4: one-hot current value, one of 1, 2, 4 or 8.
REQ-009 The block SHALL have port SEG, output, width 8: 7-segment code of value.
REQ-010 The block SHALL have port LED, output, width 8: status as {flag, 0, state[1:0], value[3:0]}.

Function
REQ-011 The block SHALL hold a 2-bit index idx (0..3), with value = 1 << idx.
REQ-012 SEG SHALL be a combinational decode of idx: 0->'h06, 1->'h5b, 2->'h66, 3->'h7f.
REQ-013 The FSM SHALL have three states with encodings IDLE = 0, RUN = 1 and PAUSE = 2, reported on LED[5:4].
REQ-014 The FSM SHALL transition as follows:
- IDLE->RUN when run = 1.
- RUN->PAUSE when run = 0.
- PAUSE->RUN when run = 1.
- Any state->IDLE when clr = 1.
REQ-015 On entry to RUN the prescaler SHALL be 0, and it SHALL increment on each edge while in RUN with run = 1.
REQ-016 At the edge where the prescaler equals TICK_DIV-1, idx SHALL advance and the prescaler SHALL return to 0; the first advance occurs exactly TICK_DIV edges after the edge that entered RUN.
REQ-017 With TICK_DIV = 1, idx SHALL advance on every edge in RUN after the entry edge.
REQ-018 Advance SHALL use dir sampled at the advancing edge: up wraps idx 3->0, and down wraps idx 0->3.
REQ-019 The step edge detector SHALL be step & ~step_q, where step_q is step registered.
- In IDLE or PAUSE, a detected edge advances idx once at that same edge; the state is unchanged.
- In RUN, detected edges are ignored.
- step held high causes exactly one advance.
REQ-020 When run falls at the same edge as the terminal prescaler count, the FSM SHALL enter PAUSE with no advance.
REQ-021 In PAUSE, the prescaler SHALL be held, then cleared on re-entry to RUN.
REQ-022 clr SHALL take priority over run and step: idx = 0, state = IDLE, prescaler = 0 at the next edge.
REQ-023 A step edge coincident with clr SHALL be discarded.
REQ-024 A step edge coincident with an IDLE->RUN transition SHALL be discarded.
REQ-025 LED[6] SHALL be 0; LED[7] SHALL be the bounce flag when configured (REQ-031), else 0.

Reset
REQ-026 reset SHALL take priority over all inputs, including clr.
REQ-027 At the first edge with reset = 1, the block SHALL set idx = 0, state = IDLE, prescaler = 0, step_q = 1 and the bounce flag = 0.
REQ-028 After reset, outputs SHALL read value = 4'b0001, SEG = 'h06 and LED = 8'h01.
REQ-029 Because step_q resets to 1, step held high through reset release SHALL NOT cause an advance.
REQ-030 Reset asserted mid-RUN SHALL abandon any pending advance.

Configuration
REQ-031 With macro SEG_SEQ_BOUNCE_EN defined, the block SHALL ignore dir and use an internal bounce flag (0 = up), yielding the ping-pong sequence 1,2,4,8,4,2,1,2,...
- At an advance from idx 3 the flag is set and idx goes to 2.
- At an advance from idx 0 with the flag set, the flag clears and idx goes to 1.
- step advances obey the same rule.
- clr clears the flag.
REQ-032 Without SEG_SEQ_BOUNCE_EN, the bounce flag logic SHALL be absent, LED[7] SHALL be 0, and dir SHALL govern per REQ-018.

Verification
REQ-033 Bench scenario, reset release: reset high 2 cycles then low, with run = 0 and step = 1 held -> value = 1, SEG = 'h06, LED = 'h01, and no advance for 10 cycles.
REQ-034 Bench scenario, auto advance: TICK_DIV = 4, run = 1, dir = 0 -> state = RUN after 1 edge; value changes 1->2->4->8->1 at 4, 8, 12 and 16 edges after entry.
REQ-035 Bench scenario, pause and step: run drops while value = 4 -> LED[5:4] = 2; then three step pulses with dir = 1 -> value 2, 1, 8; SEG = 'h7f.
REQ-036 Bench scenario, simultaneous events:
- run falls at the terminal prescaler edge -> no advance.
- clr with step in the same cycle -> value = 1, state = IDLE.
REQ-037 Bench scenario, reset mid-operation: reset asserted in RUN with prescaler = 3 -> next edge value = 1, state = IDLE, prescaler = 0.
REQ-038 Bench scenario, bounce mode: with SEG_SEQ_BOUNCE_EN and TICK_DIV = 1, run = 1 -> value 1,2,4,8,4,2,1,2 on consecutive edges; LED[7] is high during the descending run.
